// File: rtl/branch_sequencer.sv
// branch_sequencer: decode, static backward-taken/forward-not-taken prediction, alternate-path FIFO
// and one-cycle mispredict redirect. Define BRANCH_SEQ_STATS_EN for saturating pred/miss counters.
module branch_sequencer #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] true_PC,
    input  logic [15:0] fetch_instr,
    input  logic        fetch_valid,
    input  logic [7:0]  stall_in,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    output logic [15:0] PC_next,
    output logic [15:0] LBPC,
    output logic        branch_fail,
    output logic        pred_stall,
    output logic        resolve_underflow
`ifdef BRANCH_SEQ_STATS_EN
    ,
    output logic [15:0] pred_count,
    output logic [15:0] miss_count
`endif
);
    logic [15:0] seq, tgt10, tgt13;
    logic is_cond, is_bra, is_bl, full, empty, resolving, mispredict, pop_ok, push;
    logic [PTR_W:0] count;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic pred_q [DEPTH];
    logic [15:0] alt_q [DEPTH];

    always_comb begin
        seq = true_PC + 16'd2;
        tgt10 = seq + {{5{fetch_instr[9]}}, fetch_instr[9:0], 1'b0};
        tgt13 = seq + {{2{fetch_instr[12]}}, fetch_instr[12:0], 1'b0};
        is_cond = fetch_valid && fetch_instr[15:13] == 3'b001 && fetch_instr[12:10] != 3'b111;
        is_bra = fetch_valid && fetch_instr[15:13] == 3'b001 && fetch_instr[12:10] == 3'b111;
        is_bl = fetch_valid && fetch_instr[15:13] == 3'b000;
        full = count == (PTR_W+1)'(DEPTH);
        empty = count == '0;
        resolving = resolve_valid && !branch_fail && !empty;
        mispredict = resolving && resolve_taken != pred_q[rd_ptr];
        pop_ok = resolving && !mispredict;
        // a correct resolve frees a slot in the same cycle, so a full FIFO can still accept
        push = is_cond && stall_in == 8'd0 && !branch_fail && !mispredict && (!full || pop_ok);
        pred_stall = !rst && is_cond && full;
        PC_next = rst ? 16'd0 : pred_stall ? true_PC : is_cond ? (fetch_instr[9] ? tgt10 : seq) :
                  is_bra ? tgt10 : is_bl ? tgt13 : seq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            LBPC <= 16'd0;
            branch_fail <= 1'b0;
            resolve_underflow <= 1'b0;
        end else begin
            branch_fail <= mispredict;
            resolve_underflow <= resolve_valid && !branch_fail && empty;
            if (mispredict) begin
                LBPC <= alt_q[rd_ptr];
                count <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop_ok);
            end
        end
    end

    // entry storage is only read while the FIFO is non-empty, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pred_q[wr_ptr] <= fetch_instr[9];
            alt_q[wr_ptr] <= fetch_instr[9] ? seq : tgt10;
        end
    end

`ifdef BRANCH_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_count <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (push && pred_count != 16'hFFFF) pred_count <= pred_count + 16'd1;
            if (mispredict && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_branch_sequencer;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] true_PC = 16'd0, fetch_instr = 16'd0;
    logic fetch_valid = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0;
    logic [7:0] stall_in = 8'd0;
    logic [15:0] PC_next, LBPC;
    logic branch_fail, pred_stall, resolve_underflow;
`ifdef BRANCH_SEQ_STATS_EN
    logic [15:0] pred_count, miss_count;
`endif

    branch_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .true_PC(true_PC), .fetch_instr(fetch_instr),
        .fetch_valid(fetch_valid), .stall_in(stall_in), .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken), .PC_next(PC_next), .LBPC(LBPC),
        .branch_fail(branch_fail), .pred_stall(pred_stall), .resolve_underflow(resolve_underflow)
`ifdef BRANCH_SEQ_STATS_EN
        , .pred_count(pred_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { bit pred; logic [15:0] alt; } ent_t;
    ent_t q[$];
    bit m_bf, m_uf;
    logic [15:0] m_lbpc;
    int total = 0, bad = 0;

    // kind: 0 non-branch, 1 conditional, 2 unconditional
    function automatic void decode(output int kind, output logic [15:0] seq, output logic [15:0] tgt, output bit bwd);
        int off;
        seq = true_PC + 16'd2;
        kind = 0;
        off = 0;
        if (fetch_valid && fetch_instr[15:13] == 3'b001) begin
            off = fetch_instr[9] ? int'(fetch_instr[9:0]) - 1024 : int'(fetch_instr[9:0]);
            kind = fetch_instr[12:10] == 3'b111 ? 2 : 1;
        end else if (fetch_valid && fetch_instr[15:13] == 3'b000) begin
            off = fetch_instr[12] ? int'(fetch_instr[12:0]) - 8192 : int'(fetch_instr[12:0]);
            kind = 2;
        end
        tgt = 16'(int'(seq) + 2 * off);
        bwd = off < 0;
    endfunction

    function automatic logic [15:0] exp_pc();
        int kind;
        logic [15:0] seq, tgt;
        bit bwd;
        decode(kind, seq, tgt, bwd);
        if (rst) return 16'd0;
        if (kind == 1 && q.size() == DEPTH) return true_PC;
        if (kind == 1) return bwd ? tgt : seq;
        if (kind == 2) return tgt;
        return seq;
    endfunction

    function automatic bit exp_stall();
        int kind;
        logic [15:0] seq, tgt;
        bit bwd;
        decode(kind, seq, tgt, bwd);
        return !rst && kind == 1 && q.size() == DEPTH;
    endfunction

    task automatic model_clear();
        q.delete();
        m_bf = 0;
        m_uf = 0;
        m_lbpc = 16'd0;
    endtask

    task automatic tick();
        int kind;
        logic [15:0] seq, tgt;
        bit bwd, full, miss, uf, popped;
        ent_t e;
        decode(kind, seq, tgt, bwd);
        full = q.size() == DEPTH;
        miss = 0; uf = 0; popped = 0;
        if (resolve_valid && !m_bf) begin
            if (q.size() == 0) uf = 1;
            else begin
                e = q.pop_front();
                if (e.pred != resolve_taken) begin miss = 1; m_lbpc = e.alt; end
                else popped = 1;
            end
        end
        if (miss) q.delete();
        else if (kind == 1 && stall_in == 8'd0 && !m_bf && (!full || popped))
            q.push_back('{pred: bwd, alt: bwd ? seq : tgt});
        m_bf = miss;
        m_uf = uf;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [15:0] pc, input logic [15:0] instr, input logic fv,
                          input logic [7:0] st, input logic rv, input logic rt);
        true_PC = pc; fetch_instr = instr; fetch_valid = fv;
        stall_in = st; resolve_valid = rv; resolve_taken = rt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(16'h1234, 16'h2008, 1'b1, 8'd0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total += 5;
        if (PC_next !== 16'd0) begin bad++; $display("FAIL reset_pc got=%h want=0000", PC_next); end
        if (pred_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", pred_stall); end
        if (branch_fail !== 1'b0) begin bad++; $display("FAIL reset_bf got=%b want=0", branch_fail); end
        if (LBPC !== 16'd0) begin bad++; $display("FAIL reset_lbpc got=%h want=0000", LBPC); end
        if (resolve_underflow !== 1'b0) begin bad++; $display("FAIL reset_uf got=%b want=0", resolve_underflow); end
        rst = 1'b0;
        model_clear();
        set_in(16'd0, 16'h4000, 1'b0, 8'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_nonbranch();
        set_in(16'h0100, 16'h4000, 1'b1, 8'd0, 1'b0, 1'b0);
        #1;
        total += 2;
        if (PC_next !== 16'h0102) begin bad++; $display("FAIL nb_pc got=%h want=0102", PC_next); end
        if (pred_stall !== 1'b0) begin bad++; $display("FAIL nb_stall got=%b want=0", pred_stall); end
        tick();
        total++;
        if (branch_fail !== 1'b0) begin bad++; $display("FAIL nb_bf got=%b want=0", branch_fail); end
        set_in(16'h0102, 16'h4000, 1'b0, 8'd0, 1'b1, 1'b0);
        tick();
        total++;
        if (resolve_underflow !== 1'b1) begin bad++; $display("FAIL nb_empty_uf got=%b want=1", resolve_underflow); end
        set_in(16'h0104, 16'h4000, 1'b0, 8'd0, 1'b0, 1'b0);
        tick();
        total++;
        if (resolve_underflow !== 1'b0) begin bad++; $display("FAIL uf_pulse got=%b want=0", resolve_underflow); end
    endtask

    task automatic test_mispredict();
        set_in(16'h0200, {3'b001, 3'b000, 10'h3FC}, 1'b1, 8'd0, 1'b0, 1'b0);
        #1;
        total++;
        if (PC_next !== 16'h01FA) begin bad++; $display("FAIL bwd_pc got=%h want=01FA", PC_next); end
        tick();
        set_in(16'h01FA, 16'h4000, 1'b0, 8'd0, 1'b1, 1'b0);
        tick();
        total += 2;
        if (branch_fail !== 1'b1) begin bad++; $display("FAIL mp_bf got=%b want=1", branch_fail); end
        if (LBPC !== 16'h0202) begin bad++; $display("FAIL mp_lbpc got=%h want=0202", LBPC); end
        set_in(16'h0202, 16'h4000, 1'b0, 8'd0, 1'b0, 1'b0);
        tick();
        total += 2;
        if (branch_fail !== 1'b0) begin bad++; $display("FAIL mp_bf_drop got=%b want=0", branch_fail); end
        if (LBPC !== 16'h0202) begin bad++; $display("FAIL mp_lbpc_hold got=%h want=0202", LBPC); end
    endtask

    task automatic test_forward();
        set_in(16'h0300, {3'b001, 3'b001, 10'h010}, 1'b1, 8'd0, 1'b0, 1'b0);
        #1;
        total++;
        if (PC_next !== 16'h0302) begin bad++; $display("FAIL fwd_pc got=%h want=0302", PC_next); end
        tick();
        set_in(16'h0302, 16'h4000, 1'b0, 8'd0, 1'b1, 1'b0);
        tick();
        total++;
        if (branch_fail !== 1'b0) begin bad++; $display("FAIL fwd_bf got=%b want=0", branch_fail); end
        tick();
        total++;
        if (resolve_underflow !== 1'b1) begin bad++; $display("FAIL fwd_empty got=%b want=1", resolve_underflow); end
        set_in(16'h0304, 16'h4000, 1'b0, 8'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_uncond();
        set_in(16'hFFFE, {3'b000, 13'h0001}, 1'b1, 8'd0, 1'b0, 1'b0);
        #1;
        total += 2;
        if (PC_next !== 16'h0002) begin bad++; $display("FAIL bl_wrap got=%h want=0002", PC_next); end
        if (pred_stall !== 1'b0) begin bad++; $display("FAIL bl_stall got=%b want=0", pred_stall); end
        tick();
        set_in(16'h1000, {3'b001, 3'b111, 10'h3FF}, 1'b1, 8'd0, 1'b0, 1'b0);
        #1;
        total++;
        if (PC_next !== 16'h1000) begin bad++; $display("FAIL bra_pc got=%h want=1000", PC_next); end
        tick();
        set_in(16'h1000, 16'h4000, 1'b0, 8'd0, 1'b1, 1'b0);
        tick();
        total++;
        if (resolve_underflow !== 1'b1) begin bad++; $display("FAIL uncond_nopush got=%b want=1", resolve_underflow); end
        set_in(16'h1000, 16'h4000, 1'b0, 8'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(16'h0400 + 16'(4 * i), {3'b001, 3'(i), 10'h008}, 1'b1, 8'd0, 1'b0, 1'b0);
            tick();
        end
        set_in(16'h0500, {3'b001, 3'b010, 10'h008}, 1'b1, 8'd0, 1'b0, 1'b0);
        #1;
        total += 2;
        if (pred_stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%b want=1", pred_stall); end
        if (PC_next !== 16'h0500) begin bad++; $display("FAIL full_pc got=%h want=0500", PC_next); end
        tick();
        set_in(16'h0500, {3'b001, 3'b010, 10'h008}, 1'b1, 8'd0, 1'b1, 1'b0);
        #1;
        total++;
        if (pred_stall !== 1'b1) begin bad++; $display("FAIL full_prepop_stall got=%b want=1", pred_stall); end
        tick();
        total++;
        if (branch_fail !== 1'b0) begin bad++; $display("FAIL full_pop_bf got=%b want=0", branch_fail); end
        set_in(16'h0600, {3'b001, 3'b010, 10'h008}, 1'b1, 8'd0, 1'b0, 1'b0);
        #1;
        total++;
        if (pred_stall !== 1'b1) begin bad++; $display("FAIL full_still4 got=%b want=1", pred_stall); end
        set_in(16'h0600, 16'h4000, 1'b0, 8'd0, 1'b1, 1'b1);
        tick();
        total += 2;
        if (branch_fail !== 1'b1) begin bad++; $display("FAIL full_mp_bf got=%b want=1", branch_fail); end
        if (LBPC !== 16'h0416) begin bad++; $display("FAIL full_mp_lbpc got=%h want=0416", LBPC); end
        set_in(16'h0416, 16'h4000, 1'b0, 8'd0, 1'b0, 1'b0);
        tick();
        resolve_valid = 1'b1;
        tick();
        total++;
        if (resolve_underflow !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b want=1", resolve_underflow); end
        resolve_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        set_in(16'h0600, {3'b001, 3'b011, 10'h3FE}, 1'b1, 8'd0, 1'b0, 1'b0);
        tick();
        set_in(16'h0600, 16'h4000, 1'b0, 8'd0, 1'b1, 1'b0);
        tick();
        total += 2;
        if (branch_fail !== 1'b1) begin bad++; $display("FAIL b2b_bf got=%b want=1", branch_fail); end
        if (LBPC !== 16'h0602) begin bad++; $display("FAIL b2b_lbpc got=%h want=0602", LBPC); end
        set_in(16'h0700, {3'b001, 3'b000, 10'h004}, 1'b1, 8'd0, 1'b1, 1'b1);
        tick();
        total += 2;
        if (branch_fail !== 1'b0) begin bad++; $display("FAIL b2b_onecycle got=%b want=0", branch_fail); end
        if (resolve_underflow !== 1'b0) begin bad++; $display("FAIL b2b_ignored got=%b want=0", resolve_underflow); end
        set_in(16'h0700, 16'h4000, 1'b0, 8'd0, 1'b1, 1'b0);
        tick();
        total++;
        if (resolve_underflow !== 1'b1) begin bad++; $display("FAIL b2b_nopush got=%b want=1", resolve_underflow); end
        set_in(16'h0700, 16'h4000, 1'b0, 8'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_in(16'h0800 + 16'(4 * i), {3'b001, 3'b001, 10'h3F0}, 1'b1, 8'd0, 1'b0, 1'b0);
            tick();
        end
        set_in(16'h0800, 16'h4000, 1'b0, 8'd0, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        total += 3;
        if (branch_fail !== 1'b0) begin bad++; $display("FAIL async_bf got=%b want=0", branch_fail); end
        if (LBPC !== 16'd0) begin bad++; $display("FAIL async_lbpc got=%h want=0000", LBPC); end
        if (PC_next !== 16'd0) begin bad++; $display("FAIL async_pc got=%h want=0000", PC_next); end
        resolve_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        resolve_valid = 1'b1;
        tick();
        total += 2;
        if (resolve_underflow !== 1'b1) begin bad++; $display("FAIL rstmid_uf got=%b want=1", resolve_underflow); end
        if (branch_fail !== 1'b0) begin bad++; $display("FAIL rstmid_bf got=%b want=0", branch_fail); end
        resolve_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [15:0] instr;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: instr = {3'b001, 3'($urandom_range(0, 6)), 10'($urandom)};
                3: instr = {3'b001, 3'b111, 10'($urandom)};
                4: instr = {3'b000, 13'($urandom)};
                default: instr = {3'($urandom_range(2, 7)), 13'($urandom)};
            endcase
            set_in({15'($urandom), 1'b0}, instr, $urandom_range(0, 9) != 0,
                   $urandom_range(0, 3) == 0 ? 8'(1 << $urandom_range(0, 7)) : 8'd0,
                   $urandom_range(0, 2) == 0, 1'($urandom));
            #1;
            total += 2;
            if (PC_next !== exp_pc()) begin bad++; $display("FAIL rnd_pc n=%0d got=%h want=%h", n, PC_next, exp_pc()); end
            if (pred_stall !== exp_stall()) begin bad++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, pred_stall, exp_stall()); end
            tick();
            total += 3;
            if (branch_fail !== m_bf) begin bad++; $display("FAIL rnd_bf n=%0d got=%b want=%b", n, branch_fail, m_bf); end
            if (LBPC !== m_lbpc) begin bad++; $display("FAIL rnd_lbpc n=%0d got=%h want=%h", n, LBPC, m_lbpc); end
            if (resolve_underflow !== m_uf) begin bad++; $display("FAIL rnd_uf n=%0d got=%b want=%b", n, resolve_underflow, m_uf); end
        end
    endtask

    initial begin
        test_reset();
        test_nonbranch();
        test_mispredict();
        test_forward();
        test_uncond();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Produces the next-PC, last-branch-PC and branch-fail signals consumed by the program counter register of the XM23 pipeline.
- Decodes each fetched instruction, applies a static backward-taken/forward-not-taken prediction to conditional branches, and records the alternate path for each prediction in a small FIFO.
- Compares each prediction with the execute-stage resolution. On a mispredict, it issues a one-cycle redirect to the recorded alternate PC.

Parameters:
- DEPTH, 4, number of unresolved conditional-branch predictions held (power of 2, 2..16)
- PTR_W, $clog2(DEPTH), FIFO pointer width (derived; do not override)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- true_PC  input  16  current PC from the PC register
- fetch_instr  input  16  instruction word at true_PC
- fetch_valid  input  1  fetch_instr is valid this cycle
- stall_in  input  8  pipeline stall vector; any bit set means fetch does not advance
- resolve_valid  input  1  execute stage resolves the oldest outstanding conditional branch
- resolve_taken  input  1  actual outcome of that branch
- PC_next  output  16  next PC (combinational)
- LBPC  output  16  redirect target, valid while branch_fail=1 (registered)
- branch_fail  output  1  one-cycle mispredict redirect (registered)
- pred_stall  output  1  FIFO full and a conditional branch is fetched (combinational)
- resolve_underflow  output  1  one-cycle pulse: resolve_valid arrived with the FIFO empty (registered)

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; pointers = 0.
  - LBPC = 0, branch_fail = 0, resolve_underflow = 0.
  - PC_next forced to 0; pred_stall = 0.
- Decode, with seq = true_PC + 2 (mod 2^16):
  - Conditional branch: instr[15:13]=001 and instr[12:10]!=111. Offset off10 = instr[9:0]. Target = seq + (sext(off10) << 1).
  - Unconditional: BRA (instr[15:13]=001, instr[12:10]=111, offset = instr[9:0]) or BL (instr[15:13]=000, offset = instr[12:0]). Target = seq + (sext(off) << 1).
  - Everything else is a non-branch.
- PC_next (combinational):
  - fetch_valid=0 or non-branch: seq.
  - Unconditional: target. No FIFO push.
  - Conditional with offset sign bit = 1: predict taken; PC_next = target; push {pred=1, alt=seq}.
  - Conditional with offset sign bit = 0: predict not-taken; PC_next = seq; push {pred=0, alt=target}.
  - FIFO full and a conditional branch is fetched: pred_stall=1, PC_next = true_PC, no push.
  - Address arithmetic wraps modulo 2^16.
- Push occurs only when all of these hold: fetch_valid=1, conditional branch, |stall_in=0, FIFO not full, branch_fail=0.
- Resolve, on a cycle with resolve_valid=1 and branch_fail=0:
  - FIFO empty: resolve_underflow=1 next cycle; nothing else changes.
  - FIFO non-empty: pop the oldest entry.
  - If resolve_taken != entry.pred: next cycle branch_fail=1, LBPC = entry.alt, and the whole FIFO is flushed (count=0). Any push in that same cycle is discarded.
  - If resolve_taken == entry.pred: pop only.
- Redirect:
  - branch_fail is high for exactly one cycle.
  - While branch_fail=1, resolve_valid and pushes are ignored.
  - LBPC holds its value until the next mispredict.
- Push and non-failing pop in the same cycle: count unchanged, both pointers advance. This applies even when the FIFO is full, because the pop frees a slot first. pred_stall is still computed from the pre-pop count.
- Resolves are accepted regardless of stall_in.
- Reset asserted mid-operation discards all outstanding entries immediately.

Optional Feature:
- Macro: BRANCH_SEQ_STATS_EN.
- When defined:
  - Adds outputs pred_count[15:0] (increments on every push) and miss_count[15:0] (increments on every mispredict).
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined:
  - These ports and counters do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset, then true_PC=16'h0100 with fetch_instr=16'h4000 (non-branch) -> PC_next=16'h0102, branch_fail=0, FIFO empty.
- true_PC=16'h0200, conditional branch with off10=10'h3FC (-4) -> PC_next=16'h01FA. Then resolve_valid=1, resolve_taken=0 -> next cycle branch_fail=1, LBPC=16'h0202; the cycle after, branch_fail=0.
- true_PC=16'h0300, conditional branch with off10=10'h010 -> PC_next=16'h0302. Then resolve_taken=0 -> no branch_fail, FIFO empty.
- BL at true_PC=16'hFFFE with off13=13'h0001 -> PC_next=16'h0002 (wrap), no push.
- Push DEPTH=4 forward branches, then fetch a fifth -> pred_stall=1, PC_next=true_PC. Then a correct resolve plus |stall_in=0 -> push accepted, count stays 4.
- Resolve with FIFO empty -> resolve_underflow pulses one cycle, branch_fail=0. Also: assert rst mid-queue (3 entries), release, resolve -> underflow pulse.
